// File: rtl/tick_to_level_if.sv
// Bus bundle for tick_to_level: tick/width requests in, level/status out.
// The master drives requests; the slave (the converter) returns the status.
interface tick_to_level_if #(
  parameter int WIDTH_BITS = 8,
  parameter int PEND_BITS  = 2
);
  logic                  tick;
  logic [WIDTH_BITS-1:0] width;
  logic                  level;
  logic                  busy;
  logic [PEND_BITS-1:0]  pending;
  logic                  overflow;

  modport master (
    output tick, width,
    input  level, busy, pending, overflow
  );

  modport slave (
    input  tick, width,
    output level, busy, pending, overflow
  );
endinterface

// File: rtl/tick_to_level.sv
// Converts 1-cycle ticks into level pulses of programmable width, queueing ticks that land mid-pulse.
// Define TICK_TO_LEVEL_RETRIGGER_EN to make ticks during the high phase extend the pulse instead.
module tick_to_level #(
  parameter int WIDTH_BITS  = 8,
  parameter int GAP_CYCLES  = 1,
  parameter int MAX_PENDING = 3
) (
  input logic           clk,
  input logic           reset,
  tick_to_level_if.slave bus
);
  localparam int PEND_BITS = $clog2(MAX_PENDING + 1);
  localparam int GAP_BITS  = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;

  state_t                state_q, state_d;
  logic [WIDTH_BITS-1:0] cnt_q, cnt_d;
  logic [GAP_BITS-1:0]   gap_q, gap_d;
  logic [PEND_BITS-1:0]  pending_q, pending_d;
  logic                  overflow_q, overflow_d;
  logic [WIDTH_BITS-1:0] w_start;
  logic                  queue_tick;
  logic                  consume;

  // A zero width still produces a one-cycle pulse.
  assign w_start = (bus.width == '0) ? WIDTH_BITS'(1) : bus.width;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gap_d      = gap_q;
    pending_d  = pending_q;
    overflow_d = 1'b0;
    queue_tick = 1'b0;
    consume    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.tick) begin
          state_d = HIGH;
          cnt_d   = w_start;
        end
      end
      HIGH: begin
        if (cnt_q <= WIDTH_BITS'(1)) begin
          state_d = GAP;
          gap_d   = GAP_BITS'(GAP_CYCLES);
        end else begin
          cnt_d = cnt_q - WIDTH_BITS'(1);
        end
`ifdef TICK_TO_LEVEL_RETRIGGER_EN
        if (bus.tick) begin
          state_d = HIGH;
          cnt_d   = w_start;
        end
`else
        queue_tick = bus.tick;
`endif
      end
      GAP: begin
        if (gap_q <= GAP_BITS'(1)) begin
          // Queued work goes first; a fresh tick then joins the queue behind it.
          if (pending_q != '0) begin
            state_d    = HIGH;
            cnt_d      = w_start;
            consume    = 1'b1;
            queue_tick = bus.tick;
          end else if (bus.tick) begin
            state_d = HIGH;
            cnt_d   = w_start;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d      = gap_q - GAP_BITS'(1);
          queue_tick = bus.tick;
        end
      end
      default: state_d = IDLE;
    endcase

    if (consume && !queue_tick) begin
      pending_d = pending_q - PEND_BITS'(1);
    end else if (queue_tick && !consume) begin
      if (pending_q < PEND_BITS'(MAX_PENDING)) begin
        pending_d = pending_q + PEND_BITS'(1);
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      gap_q      <= '0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gap_q      <= gap_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.level    = (state_q == HIGH);
  assign bus.busy     = (state_q != IDLE);
  assign bus.pending  = pending_q;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_tick_to_level.sv
// Self-checking bench for tick_to_level: per-cycle vector table fed through an expectation queue,
// plus a hand-written latency/zero-width sequence. Honours TICK_TO_LEVEL_RETRIGGER_EN.
module tb_tick_to_level;
  localparam int WIDTH_BITS  = 8;
  localparam int GAP_CYCLES  = 1;
  localparam int MAX_PENDING = 3;
  localparam int PEND_BITS   = 2;

  typedef struct {
    logic                  rst;
    logic                  tick;
    logic [WIDTH_BITS-1:0] width;
    logic                  level;
    logic                  busy;
    logic [PEND_BITS-1:0]  pending;
    logic                  overflow;
  } vec_t;

  typedef struct {
    int                   idx;
    logic                 level;
    logic                 busy;
    logic [PEND_BITS-1:0] pending;
    logic                 overflow;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  vec_t vecs[$];
  exp_t exp_q[$];

  tick_to_level_if #(.WIDTH_BITS(WIDTH_BITS), .PEND_BITS(PEND_BITS)) bus ();

  tick_to_level #(
    .WIDTH_BITS (WIDTH_BITS),
    .GAP_CYCLES (GAP_CYCLES),
    .MAX_PENDING(MAX_PENDING)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic add(input logic rst, input logic tick, input logic [WIDTH_BITS-1:0] width,
                     input logic level, input logic busy, input logic [PEND_BITS-1:0] pending,
                     input logic overflow, input int n);
    vec_t v;
    v.rst = rst; v.tick = tick; v.width = width;
    v.level = level; v.busy = busy; v.pending = pending; v.overflow = overflow;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input int actual, input int required);
    n_checks++;
    if (actual != required) begin
      n_fail++;
      $display("[TB] FAIL %s vec %0d: got %0d expected %0d", name, idx, actual, required);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    check("level",    e.idx, int'(bus.level),    int'(e.level));
    check("busy",     e.idx, int'(bus.busy),     int'(e.busy));
    check("pending",  e.idx, int'(bus.pending),  int'(e.pending));
    check("overflow", e.idx, int'(bus.overflow), int'(e.overflow));
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    exp_t e;
    reset    = v.rst;
    bus.tick = v.tick;
    bus.width = v.width;
    e.idx = idx; e.level = v.level; e.busy = v.busy; e.pending = v.pending; e.overflow = v.overflow;
    exp_q.push_back(e);
  endtask

  initial begin
    int hi_cnt;
    bit seen;
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    bus.tick  = 1'b0;
    bus.width = '0;

    // reset
    add(1, 0, 4, 0, 0, 0, 0, 2);
    // width 4 single tick; width change mid-pulse must not matter
    add(0, 1, 4, 1, 1, 0, 0, 1);
    add(0, 0, 9, 1, 1, 0, 0, 3);
    add(0, 0, 4, 0, 1, 0, 0, 1);
    add(0, 0, 4, 0, 0, 0, 0, 2);
    // width 0 treated as 1
    add(0, 1, 0, 1, 1, 0, 0, 1);
    add(0, 0, 0, 0, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1);
`ifdef TICK_TO_LEVEL_RETRIGGER_EN
    // ticks at t and t+2 stretch the pulse to 6 cycles
    add(0, 1, 4, 1, 1, 0, 0, 1);
    add(0, 0, 4, 1, 1, 0, 0, 1);
    add(0, 1, 4, 1, 1, 0, 0, 1);
    add(0, 0, 4, 1, 1, 0, 0, 3);
    add(0, 0, 4, 0, 1, 0, 0, 1);
    add(0, 0, 4, 0, 0, 0, 0, 1);
    // back-to-back retriggers, then a tick at the gap exit starts a new pulse
    add(0, 1, 2, 1, 1, 0, 0, 3);
    add(0, 0, 2, 1, 1, 0, 0, 1);
    add(0, 0, 2, 0, 1, 0, 0, 1);
    add(0, 1, 2, 1, 1, 0, 0, 1);
    add(0, 0, 2, 1, 1, 0, 0, 1);
    add(0, 0, 2, 0, 1, 0, 0, 1);
    add(0, 0, 2, 0, 0, 0, 0, 1);
    // reset mid-pulse
    add(0, 1, 8, 1, 1, 0, 0, 1);
    add(0, 0, 8, 1, 1, 0, 0, 1);
    add(1, 0, 8, 0, 0, 0, 0, 1);
    add(0, 0, 8, 0, 0, 0, 0, 4);
`else
    // width 3, three consecutive ticks
    add(0, 1, 3, 1, 1, 0, 0, 1);
    add(0, 1, 3, 1, 1, 1, 0, 1);
    add(0, 1, 3, 1, 1, 2, 0, 1);
    add(0, 0, 3, 0, 1, 2, 0, 1);
    add(0, 0, 3, 1, 1, 1, 0, 3);
    add(0, 0, 3, 0, 1, 1, 0, 1);
    add(0, 0, 3, 1, 1, 0, 0, 3);
    add(0, 0, 3, 0, 1, 0, 0, 1);
    add(0, 0, 3, 0, 0, 0, 0, 1);
    // gap exit: direct use with empty queue, and queued+new tick leaves pending unchanged
    add(0, 1, 2, 1, 1, 0, 0, 1);
    add(0, 0, 2, 1, 1, 0, 0, 1);
    add(0, 0, 2, 0, 1, 0, 0, 1);
    add(0, 1, 2, 1, 1, 0, 0, 1);
    add(0, 1, 2, 1, 1, 1, 0, 1);
    add(0, 0, 2, 0, 1, 1, 0, 1);
    add(0, 1, 2, 1, 1, 1, 0, 1);
    add(0, 0, 2, 1, 1, 1, 0, 1);
    add(0, 0, 2, 0, 1, 1, 0, 1);
    add(0, 0, 2, 1, 1, 0, 0, 2);
    add(0, 0, 2, 0, 1, 0, 0, 1);
    add(0, 0, 2, 0, 0, 0, 0, 1);
    // queue saturation: 5 ticks, 3 queued, 1 dropped, 4 pulses of width 6
    add(0, 1, 6, 1, 1, 0, 0, 1);
    add(0, 1, 6, 1, 1, 1, 0, 1);
    add(0, 1, 6, 1, 1, 2, 0, 1);
    add(0, 1, 6, 1, 1, 3, 0, 1);
    add(0, 1, 6, 1, 1, 3, 1, 1);
    add(0, 0, 6, 1, 1, 3, 0, 1);
    add(0, 0, 6, 0, 1, 3, 0, 1);
    add(0, 0, 6, 1, 1, 2, 0, 6);
    add(0, 0, 6, 0, 1, 2, 0, 1);
    add(0, 0, 6, 1, 1, 1, 0, 6);
    add(0, 0, 6, 0, 1, 1, 0, 1);
    add(0, 0, 6, 1, 1, 0, 0, 6);
    add(0, 0, 6, 0, 1, 0, 0, 1);
    add(0, 0, 6, 0, 0, 0, 0, 1);
    // reset in a width-8 pulse with two queued ticks
    add(0, 1, 8, 1, 1, 0, 0, 1);
    add(0, 1, 8, 1, 1, 1, 0, 1);
    add(0, 1, 8, 1, 1, 2, 0, 1);
    add(1, 1, 8, 0, 0, 0, 0, 1);
    add(0, 0, 8, 0, 0, 0, 0, 10);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
      applyStimulus(vecs[i], i);
    end
    @(negedge clk);
    while (exp_q.size() > 0) checkOutput(exp_q.pop_front());

    // hand sequence: no tick->level path, then bounded wait for a 1-cycle pulse
    reset     = 1'b0;
    bus.tick  = 1'b1;
    bus.width = '0;
    #1;
    check("no_comb_path", -1, int'(bus.level), 0);
    @(negedge clk);
    bus.tick = 1'b0;
    seen   = 1'b0;
    hi_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.level) begin
        seen = 1'b1;
        hi_cnt++;
      end
      @(negedge clk);
    end
    check("pulse_seen", -1, int'(seen), 1);
    check("pulse_len",  -1, hi_cnt, 1);
    check("idle_busy",  -1, int'(bus.busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
